// File: rtl/uart_resp_pkg.sv
// Shared types and constants for the UART response collector.
package uart_resp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HUNT  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_PAR   = 3'd4,
        ST_STOP  = 3'd5
    } state_e;

    // Sample points relative to P/2: early = P/2-1, mid = P/2, late = P/2+1.
    localparam int unsigned SMP_EARLY_OFS = 1;
    localparam int unsigned SMP_MID_OFS   = 0;
    localparam int unsigned SMP_LATE_OFS  = 1;

    localparam logic BYTE0_IDX = 1'b0;
    localparam logic BYTE1_IDX = 1'b1;

endpackage

// File: rtl/uart_bit_sampler.sv
// Per-bit edge counter with three-point majority vote around mid-bit.
module uart_bit_sampler
    import uart_resp_pkg::*;
#(
    parameter int unsigned PRESCALE_WD = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx_s_i,
    input  logic [PRESCALE_WD-1:0] prescale_i,
    input  logic                   enable_i,
    output logic                   bit_val_c_o,
    output logic                   sample_done_c_o,
    output logic                   bit_done_c_o
);

    logic [PRESCALE_WD-1:0] edge_cnt_q, edge_cnt_d;
    logic [PRESCALE_WD-1:0] half;
    logic [PRESCALE_WD-1:0] pt_early;
    logic [PRESCALE_WD-1:0] pt_mid;
    logic [PRESCALE_WD-1:0] pt_late;
    logic                   s_early_q, s_early_d;
    logic                   s_mid_q, s_mid_d;

    assign half     = prescale_i >> 1;
    assign pt_early = half - PRESCALE_WD'(SMP_EARLY_OFS);
    assign pt_mid   = half + PRESCALE_WD'(SMP_MID_OFS);
    assign pt_late  = half + PRESCALE_WD'(SMP_LATE_OFS);

    assign bit_done_c_o    = enable_i && (edge_cnt_q == (prescale_i - PRESCALE_WD'(1)));
    assign sample_done_c_o = enable_i && (edge_cnt_q == pt_late);
    // Third sample is the live line value at the late sample point.
    assign bit_val_c_o     = (s_early_q & s_mid_q) | (s_early_q & rx_s_i) | (s_mid_q & rx_s_i);

    always_comb begin
        edge_cnt_d = edge_cnt_q;
        s_early_d  = s_early_q;
        s_mid_d    = s_mid_q;
        if (!enable_i) begin
            edge_cnt_d = '0;
        end else begin
            if (bit_done_c_o) begin
                edge_cnt_d = '0;
            end else begin
                edge_cnt_d = edge_cnt_q + PRESCALE_WD'(1);
            end
            if (edge_cnt_q == pt_early) begin
                s_early_d = rx_s_i;
            end
            if (edge_cnt_q == pt_mid) begin
                s_mid_d = rx_s_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt_q <= '0;
            s_early_q  <= 1'b1;
            s_mid_q    <= 1'b1;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            s_early_q  <= s_early_d;
            s_mid_q    <= s_mid_d;
        end
    end

endmodule

// File: rtl/uart_resp_collector.sv
// Oversampling UART receiver that collects one armed 1- or 2-byte response.
module uart_resp_collector
    import uart_resp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned PRESCALE_WD = 6,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                    clk,
    input  logic                    RST,
    input  logic                    RX_IN,
    input  logic [PRESCALE_WD-1:0]  Prescale,
    input  logic                    PAR_EN,
    input  logic                    PAR_TYP,
    input  logic                    exp_len,
    input  logic                    arm,
    output logic                    busy,
    output logic [2*DATA_WIDTH-1:0] resp_data,
    output logic                    resp_valid,
    output logic                    resp_err,
    output logic                    timeout
);

    localparam int unsigned BIT_CNT_W = $clog2(DATA_WIDTH + 1);
    localparam int unsigned TMO_W     = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    state_e                  state_q, state_d;
    logic                    sync1_q, rx_s_q, rx_prev_q;
    logic [PRESCALE_WD-1:0]  prescale_q, prescale_d;
    logic                    exp_len_q, exp_len_d;
    logic                    par_en_q, par_en_d;
    logic                    par_typ_q, par_typ_d;
    logic                    byte_cnt_q, byte_cnt_d;
    logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [DATA_WIDTH-1:0]   byte0_q, byte0_d;
    logic                    err_q, err_d;
    logic [TMO_W-1:0]        tmo_cnt_q, tmo_cnt_d;
    logic                    busy_q, busy_d;
    logic [2*DATA_WIDTH-1:0] resp_data_q, resp_data_d;
    logic                    resp_valid_q, resp_valid_d;
    logic                    resp_err_q, resp_err_d;
    logic                    timeout_q, timeout_d;

    logic rx_fall;
    logic tmo_hit;
    logic smp_en;
    logic bit_val;
    logic sample_done;
    logic bit_done;
    logic last_bit;
    logic frame_bad;
    logic final_byte;

    assign rx_fall    = rx_prev_q & ~rx_s_q;
    assign tmo_hit    = (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));
    assign smp_en     = (state_q == ST_START) || (state_q == ST_DATA) ||
                        (state_q == ST_PAR)   || (state_q == ST_STOP);
    assign last_bit   = (bit_cnt_q == BIT_CNT_W'(DATA_WIDTH));
    assign frame_bad  = err_q || !bit_val;
    assign final_byte = (byte_cnt_q == exp_len_q);

    uart_bit_sampler #(
        .PRESCALE_WD (PRESCALE_WD)
    ) u_sampler (
        .clk             (clk),
        .rst_n           (RST),
        .rx_s_i          (rx_s_q),
        .prescale_i      (prescale_q),
        .enable_i        (smp_en),
        .bit_val_c_o     (bit_val),
        .sample_done_c_o (sample_done),
        .bit_done_c_o    (bit_done)
    );

    // Two-flop synchronizer plus edge-detect history; idle-high reset.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            sync1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            sync1_q   <= RX_IN;
            rx_s_q    <= sync1_q;
            rx_prev_q <= rx_s_q;
        end
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (arm) state_d = ST_HUNT;
            end
            ST_HUNT: begin
                if (tmo_hit)      state_d = ST_IDLE;
                else if (rx_fall) state_d = ST_START;
            end
            ST_START: begin
                if (sample_done && bit_val) state_d = ST_HUNT;
                else if (bit_done)          state_d = ST_DATA;
            end
            ST_DATA: begin
                if (bit_done && last_bit) state_d = par_en_q ? ST_PAR : ST_STOP;
            end
            ST_PAR: begin
                if (bit_done) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (sample_done) begin
                    if (frame_bad || final_byte) state_d = ST_IDLE;
                    else                         state_d = ST_HUNT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        prescale_d   = prescale_q;
        exp_len_d    = exp_len_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        byte_cnt_d   = byte_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        byte0_d      = byte0_q;
        err_d        = err_q;
        tmo_cnt_d    = tmo_cnt_q;
        resp_data_d  = resp_data_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        timeout_d    = 1'b0;
        busy_d       = (state_d != ST_IDLE);
        unique case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    prescale_d = Prescale;
                    exp_len_d  = exp_len;
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                    byte_cnt_d = BYTE0_IDX;
                    tmo_cnt_d  = '0;
                    err_d      = 1'b0;
                end
            end
            ST_HUNT: begin
                if (tmo_hit) begin
                    timeout_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                    if (rx_fall) begin
                        bit_cnt_d = '0;
                        err_d     = 1'b0;
                    end
                end
            end
            ST_DATA: begin
                if (sample_done) begin
                    shift_d   = {bit_val, shift_q[DATA_WIDTH-1:1]};
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                end
            end
            ST_PAR: begin
                if (sample_done && (bit_val != ((^shift_q) ^ par_typ_q))) begin
                    err_d = 1'b1;
                end
            end
            ST_STOP: begin
                if (sample_done) begin
                    if (frame_bad) begin
                        resp_err_d = 1'b1;
                    end else if (final_byte) begin
                        resp_valid_d = 1'b1;
                        resp_data_d  = (byte_cnt_q == BYTE1_IDX) ? {shift_q, byte0_q}
                                                                 : {DATA_WIDTH'(0), shift_q};
                    end else begin
                        byte0_d    = shift_q;
                        byte_cnt_d = BYTE1_IDX;
                        tmo_cnt_d  = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            prescale_q   <= '0;
            exp_len_q    <= 1'b0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            byte_cnt_q   <= BYTE0_IDX;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            byte0_q      <= '0;
            err_q        <= 1'b0;
            tmo_cnt_q    <= '0;
            busy_q       <= 1'b0;
            resp_data_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            prescale_q   <= prescale_d;
            exp_len_q    <= exp_len_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            byte_cnt_q   <= byte_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            byte0_q      <= byte0_d;
            err_q        <= err_d;
            tmo_cnt_q    <= tmo_cnt_d;
            busy_q       <= busy_d;
            resp_data_q  <= resp_data_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            timeout_q    <= timeout_d;
        end
    end

    assign busy       = busy_q;
    assign resp_data  = resp_data_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_uart_resp_collector.sv
// Scoreboard bench for uart_resp_collector: directed frames, monitor checks each completion pulse.
module tb_uart_resp_collector;

    localparam int unsigned TMO = 64;

    logic        clk = 1'b0;
    logic        RST;
    logic        RX_IN;
    logic [5:0]  Prescale;
    logic        PAR_EN;
    logic        PAR_TYP;
    logic        exp_len;
    logic        arm;
    logic        busy;
    logic [15:0] resp_data;
    logic        resp_valid;
    logic        resp_err;
    logic        timeout;

    localparam logic [2:0] K_VALID = 3'b001;
    localparam logic [2:0] K_ERR   = 3'b010;
    localparam logic [2:0] K_TMO   = 3'b100;

    typedef struct {
        logic [2:0]  kind;
        logic [15:0] data;
        bit          chk_data;
        bit          chk_lat;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   rise_cyc = 0;
    logic busy_prev = 1'b0;

    uart_resp_collector #(
        .DATA_WIDTH  (8),
        .PRESCALE_WD (6),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk        (clk),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .Prescale   (Prescale),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .exp_len    (exp_len),
        .arm        (arm),
        .busy       (busy),
        .resp_data  (resp_data),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [2:0] kind, input logic [15:0] data,
                        input bit cd, input bit cl);
        exp_t e;
        e.kind = kind; e.data = data; e.chk_data = cd; e.chk_lat = cl;
        q.push_back(e);
    endtask

    // Monitor: pops expected completion on every pulse.
    always @(negedge clk) begin
        cyc++;
        if (busy && !busy_prev) rise_cyc = cyc;
        busy_prev = busy;
        if (resp_valid || resp_err || timeout) begin
            if (q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_pulse: got v=%0b e=%0b t=%0b expected none",
                         resp_valid, resp_err, timeout);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pulse_kind", 32'({timeout, resp_err, resp_valid}), 32'(e.kind));
                if (e.chk_data) chk("resp_data", 32'(resp_data), 32'(e.data));
                if (e.chk_lat) chk("timeout_latency", 32'(cyc - rise_cyc), 32'(TMO));
                chk("busy_at_done", 32'(busy), 32'(0));
            end
        end
    end

    task automatic drive(input logic v, input int n);
        RX_IN = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_arm(input int p, input logic pe, input logic pt, input logic el);
        Prescale = 6'(p);
        PAR_EN   = pe;
        PAR_TYP  = pt;
        exp_len  = el;
        arm      = 1'b1;
        @(posedge clk);
        #1;
        arm = 1'b0;
    endtask

    task automatic send_byte(input int p, input logic [7:0] b, input logic pe, input logic pt,
                             input logic bad_par, input logic stop_v);
        logic par;
        par = (^b) ^ pt ^ bad_par;
        drive(1'b0, p);
        for (int i = 0; i < 8; i++) drive(b[i], p);
        if (pe) drive(par, p);
        drive(stop_v, p);
        RX_IN = 1'b1;
    endtask

    task automatic wait_done(input string name, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (!busy) break;
            @(posedge clk);
            #1;
        end
        if (busy) begin
            n_chk++;
            n_err++;
            $display("FAIL %s_wait: got busy=1 expected busy=0 within %0d cycles", name, limit);
        end
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_pending"}, 32'(q.size()), 32'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b0; RX_IN = 1'b1; Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        exp_len = 1'b0; arm = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_data", 32'(resp_data), 32'(0));
        chk("rst_valid", 32'(resp_valid), 32'(0));
        chk("rst_err", 32'(resp_err), 32'(0));
        chk("rst_timeout", 32'(timeout), 32'(0));
        RST = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // 1-byte, P=8, no parity
        push(K_VALID, 16'h00A5, 1, 0);
        do_arm(8, 0, 0, 0);
        chk("busy_after_arm", 32'(busy), 32'(1));
        send_byte(8, 8'hA5, 0, 0, 0, 1);
        wait_done("a5", 50);

        // 2-byte, P=16, even parity
        push(K_VALID, 16'h1234, 1, 0);
        do_arm(16, 1, 0, 1);
        send_byte(16, 8'h34, 1, 0, 0, 1);
        send_byte(16, 8'h12, 1, 0, 0, 1);
        wait_done("1234", 100);

        // P=32 odd parity, wrong parity bit: error, data held
        push(K_ERR, 16'h1234, 1, 0);
        do_arm(32, 1, 1, 0);
        send_byte(32, 8'h0F, 1, 1, 1, 1);
        wait_done("par_err", 100);

        // Stop bit low: framing error
        push(K_ERR, 16'h1234, 1, 0);
        do_arm(8, 0, 0, 0);
        send_byte(8, 8'h3C, 0, 0, 0, 0);
        drive(1'b1, 4);
        wait_done("frm_err", 50);

        // Short low glitch in HUNT is rejected, next byte still collected
        push(K_VALID, 16'h005A, 1, 0);
        do_arm(8, 0, 0, 0);
        drive(1'b0, 2);
        drive(1'b1, 12);
        send_byte(8, 8'h5A, 0, 0, 0, 1);
        wait_done("glitch", 50);

        // Idle line: timeout exactly TMO cycles after busy rises
        push(K_TMO, 16'h0, 0, 1);
        do_arm(8, 0, 0, 0);
        wait_done("tmo_idle", 200);

        // Two-byte request with only byte0 delivered
        push(K_TMO, 16'h0, 0, 0);
        do_arm(8, 0, 0, 1);
        send_byte(8, 8'h77, 0, 0, 0, 1);
        wait_done("tmo_byte1", 200);

        // Reset in the middle of byte0 data bits
        do_arm(16, 0, 0, 0);
        drive(1'b0, 16);
        drive(1'b1, 16);
        drive(1'b0, 8);
        RST = 1'b0;
        RX_IN = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_busy", 32'(busy), 32'(0));
        chk("midrst_data", 32'(resp_data), 32'(0));
        chk("midrst_pulses", 32'({timeout, resp_err, resp_valid}), 32'(0));
        RST = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Clean byte after reset; a second arm while busy must be ignored
        push(K_VALID, 16'h00C3, 1, 0);
        do_arm(16, 0, 0, 0);
        do_arm(8, 1, 1, 1);
        send_byte(16, 8'hC3, 0, 0, 0, 1);
        wait_done("c3", 100);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
